wb_burst_writer: RTL

WB_BURST_WRITER -- requirements
Module: wb_burst_writer

---
 rtl/wb_burst_writer_pkg.sv | 16 +
 rtl/wb_burst_writer_fifo.sv | 56 +++++
 rtl/wb_burst_writer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_writer_pkg.sv
// Shared types and Wishbone constants for the burst writer.
package wb_burst_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_burst_writer_fifo.sv
// Synchronous FIFO, depth 2**AW; clr empties it in one cycle, a full FIFO
// accepts a push when a pop happens on the same edge.
module wb_burst_writer_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_burst_writer.sv
// Stream-to-Wishbone incrementing burst writer.
// Optional bus-error abort is built when WB_BURST_WRITER_ERR_EN is defined.
module wb_burst_writer
    import wb_burst_writer_pkg::*;
#(
    parameter int unsigned dw        = 32,
    parameter int unsigned aw        = 32,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          start_i,
    input  logic [aw-1:0] start_adr_i,
    input  logic [15:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    input  logic [dw-1:0] stream_data_i,
    input  logic          stream_valid_i,
    output logic          stream_ready_o,
    output logic [aw-1:0] wbm_adr_o,
    output logic [dw-1:0] wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);
    localparam int unsigned LW  = 16;
    localparam int unsigned LVW = FIFO_AW + 1;

    logic           rst_meta, rst_s;
    state_t         state, state_nxt;
    logic           cyc, busy, done;
    logic           cyc_d, busy_d, done_d;
    logic [aw-1:0]  adr;
    logic [LW-1:0]  len_q, remaining, accepted, beats, burst_n;
    logic           fifo_full, unused_fifo_empty;
    logic [LVW-1:0] fifo_level;
    logic [dw-1:0]  fifo_head;
    logic           start_ok, fill_ok, ack_beat, last_beat, err_beat;
    logic           push, pop, clr;

    // Reset asserts asynchronously, releases two clocks later.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rst_meta <= 1'b0;
            rst_s    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_s    <= rst_meta;
        end
    end

    assign start_ok  = (state == ST_IDLE) && start_i;
    assign burst_n   = (remaining > LW'(BURST_LEN)) ? LW'(BURST_LEN) : remaining;
    assign fill_ok   = (LW'(fifo_level) >= burst_n);
    assign ack_beat  = (state == ST_BURST) && wbm_ack_i && !err_beat;
    assign last_beat = ack_beat && (beats == LW'(1));
    assign push      = stream_valid_i && stream_ready_o;
    assign pop       = ack_beat;
    assign clr       = start_ok || err_beat;

`ifdef WB_BURST_WRITER_ERR_EN
    logic err_q;

    assign err_beat       = (state == ST_BURST) && wbm_err_i;
    assign stream_ready_o = busy && !fifo_full && (accepted < len_q) && !err_q;
    assign err_o          = err_q;

    always_ff @(posedge wb_clk_i or negedge rst_s) begin
        if (!rst_s)        err_q <= 1'b0;
        else if (start_ok) err_q <= 1'b0;
        else if (err_beat) err_q <= 1'b1;
    end
`else
    logic unused_err;

    assign unused_err     = wbm_err_i;
    assign err_beat       = 1'b0;
    assign stream_ready_o = busy && !fifo_full && (accepted < len_q);
    assign err_o          = 1'b0;
`endif

    // State register with registered control outputs.
    always_ff @(posedge wb_clk_i or negedge rst_s) begin
        if (!rst_s) begin
            state <= ST_IDLE;
            cyc   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = (len_i == '0) ? ST_DONE : ST_FILL;
            ST_FILL:  if (fill_ok) state_nxt = ST_BURST;
            ST_BURST: begin
                if (err_beat)       state_nxt = ST_DONE;
                else if (last_beat) state_nxt = (remaining == LW'(1)) ? ST_DONE : ST_FILL;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they register with it.
    always_comb begin
        cyc_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_nxt)
            ST_FILL:  busy_d = 1'b1;
            ST_BURST: begin
                busy_d = 1'b1;
                cyc_d  = 1'b1;
            end
            ST_DONE:  begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_s) begin
        if (!rst_s) begin
            adr       <= '0;
            len_q     <= '0;
            remaining <= '0;
            accepted  <= '0;
            beats     <= '0;
        end else if (start_ok) begin
            adr       <= start_adr_i;
            len_q     <= len_i;
            remaining <= len_i;
            accepted  <= '0;
            beats     <= '0;
        end else begin
            if (push) accepted <= accepted + LW'(1);
            if ((state == ST_FILL) && fill_ok) beats <= burst_n;
            if (ack_beat) begin
                adr       <= adr + aw'(4);
                remaining <= remaining - LW'(1);
                beats     <= beats - LW'(1);
            end
        end
    end

    wb_burst_writer_fifo #(
        .DW (dw),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (rst_s),
        .clr       (clr),
        .push      (push),
        .push_data (stream_data_i),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (unused_fifo_empty),
        .level     (fifo_level)
    );

    assign busy_o    = busy;
    assign done_o    = done;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = fifo_head;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = cyc;
    assign wbm_sel_o = {4{cyc}};
    assign wbm_bte_o = BTE_LINEAR;
    assign wbm_cti_o = !cyc ? CTI_CLASSIC : ((beats == LW'(1)) ? CTI_EOB : CTI_INC);

endmodule
